// File: rtl/slip_rx_deframer_pkg.sv
// slip_rx_deframer_pkg: SLIP byte codes, deframer state encoding and CRC-16/CCITT-FALSE constants.
// The per-byte CRC update function is compiled only when SLIP_CRC16_EN is defined.
package slip_rx_deframer_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_RX      = 2'd0,
        S_ESC     = 2'd1,
        S_DISCARD = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

`ifdef SLIP_CRC16_EN
    // MSB-first, non-reflected; appending the CRC big-endian leaves a zero residue.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/slip_rx_deframer_ram.sv
// slip_rx_deframer_ram: DEPTH x 8 simple dual-port frame buffer, one write port, one registered read port.
// The read register only updates on rd_en, so the presented byte holds while the consumer stalls.
module slip_rx_deframer_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slip_rx_deframer.sv
// slip_rx_deframer: SLIP decoder holding one decoded frame, then draining it over valid/ready.
// Build option: define SLIP_CRC16_EN to require and strip a trailing CRC-16/CCITT-FALSE per frame.
//
// state     | meaning
// S_RX      | collecting decoded bytes into the buffer
// S_ESC     | ESC seen, next byte selects the escaped value
// S_DISCARD | frame broken, dropping bytes until END
// S_DRAIN   | frame committed, streaming to the modulator, input dropped
module slip_rx_deframer #(
    parameter int MAX_LEN = 128,
    parameter int ADDR_W  = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      i_byte,
    input  logic            i_byte_valid,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    output logic            o_tx_last,
    input  logic            i_tx_ready,
    output logic [ADDR_W:0] o_frame_len,
    output logic            o_busy,
    output logic            o_err,
    output logic [7:0]      o_frame_cnt
);
    import slip_rx_deframer_pkg::*;

    localparam logic [ADDR_W:0] FULL_IDX = (ADDR_W+1)'(MAX_LEN);

    state_t          state;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] commit_len;
    logic            sync;
    logic            sync_next;
    logic            is_end;
    logic            is_esc;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            rd_en;
    logic            drain_done;
    logic            end_ok;
    logic            end_bad;
`ifdef SLIP_CRC16_EN
    logic [15:0]     crc;
`endif

    assign is_end    = (i_byte == SLIP_END);
    assign is_esc    = (i_byte == SLIP_ESC);
    assign sync_next = i_byte_valid ? is_end : sync;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = i_byte;
        if (i_byte_valid && (idx != FULL_IDX)) begin
            case (state)
                S_RX: wr_en = !is_end && !is_esc;
                S_ESC: begin
                    if (i_byte == SLIP_ESC_END) begin
                        wr_en   = 1'b1;
                        wr_data = SLIP_END;
                    end else if (i_byte == SLIP_ESC_ESC) begin
                        wr_en   = 1'b1;
                        wr_data = SLIP_ESC;
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

`ifdef SLIP_CRC16_EN
    assign end_bad    = (idx != '0) && ((idx < (ADDR_W+1)'(3)) || (crc != 16'h0000));
    assign end_ok     = (idx != '0) && !end_bad;
    assign commit_len = idx - (ADDR_W+1)'(2);
`else
    assign end_bad    = 1'b0;
    assign end_ok     = (idx != '0);
    assign commit_len = idx;
`endif

    // Prefetch whenever the output slot is empty or being consumed this cycle.
    assign rd_en      = (state == S_DRAIN) && (!o_tx_valid || i_tx_ready) && (rd_ptr != o_frame_len);
    assign drain_done = (state == S_DRAIN) && o_tx_valid && i_tx_ready && o_tx_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RX;
            idx         <= '0;
            rd_ptr      <= '0;
            sync        <= 1'b1;
            o_tx_valid  <= 1'b0;
            o_tx_last   <= 1'b0;
            o_frame_len <= '0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= 8'h00;
`ifdef SLIP_CRC16_EN
            crc         <= CRC16_INIT;
`endif
        end else begin
            o_err <= 1'b0;
            if (wr_en) begin
                idx <= idx + 1'b1;
            end
`ifdef SLIP_CRC16_EN
            if (wr_en) begin
                crc <= crc16_upd((idx == '0) ? CRC16_INIT : crc, wr_data);
            end
`endif
            case (state)
                S_RX: begin
                    if (i_byte_valid) begin
                        if (is_end) begin
                            if (end_ok) begin
                                o_frame_len <= commit_len;
                                o_frame_cnt <= o_frame_cnt + 1'b1;
                                rd_ptr      <= '0;
                                sync        <= 1'b1;
                                o_busy      <= 1'b1;
                                state       <= S_DRAIN;
                            end else if (end_bad) begin
                                o_err <= 1'b1;
                                idx   <= '0;
                            end
                        end else if (is_esc) begin
                            state <= S_ESC;
                        end else if (idx == FULL_IDX) begin
                            o_err <= 1'b1;
                            idx   <= '0;
                            state <= S_DISCARD;
                        end
                    end
                end
                S_ESC: begin
                    if (i_byte_valid) begin
                        if (wr_en) begin
                            state <= S_RX;
                        end else begin
                            o_err <= 1'b1;
                            idx   <= '0;
                            state <= is_end ? S_RX : S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (i_byte_valid && is_end) begin
                        idx   <= '0;
                        state <= S_RX;
                    end
                end
                S_DRAIN: begin
                    sync <= sync_next;
                    if (rd_en) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        o_tx_valid <= 1'b1;
                        o_tx_last  <= ((rd_ptr + 1'b1) == o_frame_len);
                    end else if (drain_done) begin
                        o_tx_valid <= 1'b0;
                        o_tx_last  <= 1'b0;
                        o_busy     <= 1'b0;
                        idx        <= '0;
                        state      <= sync_next ? S_RX : S_DISCARD;
                    end
                end
                default: state <= S_RX;
            endcase
        end
    end

    slip_rx_deframer_ram #(
        .DEPTH (MAX_LEN),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (idx[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (o_tx_data)
    );

endmodule

// File: tb/tb_slip_rx_deframer.sv
// tb_slip_rx_deframer: directed and randomized SLIP streams checked against a chunk-level decode model.
// Honours SLIP_CRC16_EN the same way the design does.
module tb_slip_rx_deframer;

    localparam int MAX_LEN = 128;
    localparam int ADDR_W  = 7;
`ifdef SLIP_CRC16_EN
    localparam int CRC_EXTRA = 2;
`else
    localparam int CRC_EXTRA = 0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic            clk;
    logic            reset;
    logic [7:0]      i_byte;
    logic            i_byte_valid;
    logic [7:0]      o_tx_data;
    logic            o_tx_valid;
    logic            o_tx_last;
    logic            i_tx_ready;
    logic [ADDR_W:0] o_frame_len;
    logic            o_busy;
    logic            o_err;
    logic [7:0]      o_frame_cnt;

    slip_rx_deframer #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_tx_last    (o_tx_last),
        .i_tx_ready   (i_tx_ready),
        .o_frame_len  (o_frame_len),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_frame_cnt  (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_chk = 0;
    int      n_bad = 0;
    int      exp_cnt = 0;
    int      rdy_mode = 0;
    byte_q_t got_q;
    int      last_cnt = 0;
    int      last_pos = -1;
    int      cap_len = -1;
    int      err_seen = 0;
    bit      err_prev = 1'b0;
    bit      err_consec = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_tx_valid && i_tx_ready) begin
            if (o_tx_last) begin
                last_cnt++;
                last_pos = got_q.size();
            end
            cap_len = int'(o_frame_len);
            got_q.push_back(o_tx_data);
        end
        if (o_err) begin
            err_seen++;
            if (err_prev) err_consec = 1'b1;
        end
        err_prev = o_err;
    end

    function automatic logic [15:0] crc16(input byte_q_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic byte_q_t add_crc(input byte_q_t p);
`ifdef SLIP_CRC16_EN
        logic [15:0] c;
        c = crc16(p);
        p.push_back(c[15:8]);
        p.push_back(c[7:0]);
`endif
        return p;
    endfunction

    function automatic byte_q_t slip_enc(input byte_q_t p);
        byte_q_t r;
        r = {};
        foreach (p[i]) begin
            if (p[i] == 8'hC0) begin
                r.push_back(8'hDB); r.push_back(8'hDC);
            end else if (p[i] == 8'hDB) begin
                r.push_back(8'hDB); r.push_back(8'hDD);
            end else begin
                r.push_back(p[i]);
            end
        end
        return r;
    endfunction

    // Each END closes a chunk; a chunk is an error, ignored, or the committed frame.
    task automatic model_raw(input byte_q_t raw, output byte_q_t pay, output int n_err, output int n_com);
        byte_q_t dec;
        bit      bad;
        bit      esc;
        n_err = 0; n_com = 0; pay = {}; dec = {}; bad = 1'b0; esc = 1'b0;
        foreach (raw[i]) begin
            if (raw[i] == 8'hC0) begin
                if (esc) bad = 1'b1;
                if (bad || dec.size() > MAX_LEN) begin
                    n_err++;
                end else if (dec.size() > 0) begin
`ifdef SLIP_CRC16_EN
                    if (dec.size() < 3 || crc16(dec) != 16'h0000) begin
                        n_err++;
                    end else begin
                        n_com++;
                        pay = dec[0:$-2];
                    end
`else
                    n_com++;
                    pay = dec;
`endif
                end
                dec = {}; bad = 1'b0; esc = 1'b0;
            end else if (esc) begin
                esc = 1'b0;
                if (raw[i] == 8'hDC) dec.push_back(8'hC0);
                else if (raw[i] == 8'hDD) dec.push_back(8'hDB);
                else bad = 1'b1;
            end else if (raw[i] == 8'hDB) begin
                esc = 1'b1;
            end else begin
                dec.push_back(raw[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        if (rdy_mode == 1) i_tx_ready = ($urandom_range(2, 0) != 0);
        else if (rdy_mode == 0) i_tx_ready = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < 8 * MAX_LEN) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({tag, "/drain_timeout"}, int'(o_busy), 0);
    endtask

    task automatic run_raw(input byte_q_t raw, input string tag, input bit gaps);
        byte_q_t pay;
        int      ne;
        int      nc;
        int      e0;
        model_raw(raw, pay, ne, nc);
        exp_cnt  = (exp_cnt + nc) % 256;
        got_q    = {};
        last_cnt = 0;
        last_pos = -1;
        cap_len  = -1;
        e0       = err_seen;
        foreach (raw[i]) begin
            if (gaps && $urandom_range(3, 0) == 0) repeat ($urandom_range(2, 1)) tick();
            send_byte(raw[i]);
        end
        wait_idle(tag);
        repeat (2) tick();
        chk({tag, "/err"}, err_seen - e0, ne);
        chk({tag, "/frame_cnt"}, int'(o_frame_cnt), exp_cnt);
        chk({tag, "/nbytes"}, got_q.size(), pay.size());
        chk({tag, "/lasts"}, last_cnt, nc);
        if (nc != 0) begin
            chk({tag, "/frame_len"}, cap_len, pay.size());
            chk({tag, "/last_pos"}, last_pos, pay.size() - 1);
        end
        foreach (pay[i]) begin
            if (i < got_q.size()) chk({tag, "/data"}, int'(got_q[i]), int'(pay[i]));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t raw;
        byte_q_t pay;
        reset        = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_tx_ready   = 1'b1;
        rdy_mode     = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst/valid", int'(o_tx_valid), 0);
        chk("rst/busy", int'(o_busy), 0);
        chk("rst/err", int'(o_err), 0);
        chk("rst/frame_cnt", int'(o_frame_cnt), 0);
        chk("rst/frame_len", int'(o_frame_len), 0);
        tick();
        reset = 1'b0;
        tick();

        // First valid exactly two cycles after the committing END, then one byte per clock.
        pay = {8'h01, 8'h02, 8'h03};
        raw = {8'hC0};
        raw = {raw, slip_enc(add_crc(pay)), 8'hC0};
        got_q = {};
        foreach (raw[i]) send_byte(raw[i]);
        exp_cnt++;
        @(negedge clk);
        chk("lat/early_valid", int'(o_tx_valid), 0);
        tick(); @(negedge clk);
        chk("lat/valid", int'(o_tx_valid), 1);
        chk("lat/d0", int'(o_tx_data), 1);
        chk("lat/last0", int'(o_tx_last), 0);
        chk("lat/frame_len", int'(o_frame_len), 3);
        tick(); @(negedge clk);
        chk("lat/d1", int'(o_tx_data), 2);
        chk("lat/last1", int'(o_tx_last), 0);
        tick(); @(negedge clk);
        chk("lat/d2", int'(o_tx_data), 3);
        chk("lat/last2", int'(o_tx_last), 1);
        tick(); @(negedge clk);
        chk("lat/valid_drop", int'(o_tx_valid), 0);
        chk("lat/busy_drop", int'(o_busy), 0);
        chk("lat/frame_cnt", int'(o_frame_cnt), exp_cnt);
        tick();

        raw = {8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
        run_raw(raw, "esc_pair", 1'b0);
        raw = {8'hC0, 8'hC0, 8'hC0};
        run_raw(raw, "ends_only", 1'b0);
        raw = {8'hC0, 8'h01, 8'hDB, 8'h55, 8'h02, 8'hC0, 8'h05, 8'hC0};
        run_raw(raw, "bad_esc", 1'b0);
        raw = {8'hC0};
        for (int i = 0; i < MAX_LEN + 1; i++) raw.push_back(8'h11);
        raw.push_back(8'hC0);
        run_raw(raw, "overflow", 1'b0);
        pay = {8'h07};
        raw = {slip_enc(add_crc(pay)), 8'hC0};
        run_raw(raw, "after_overflow", 1'b0);
        raw = {8'hC0};
        for (int i = 0; i < MAX_LEN - CRC_EXTRA; i++) pay[i] = 8'(i + 3);
        raw = {raw, slip_enc(add_crc(pay)), 8'hC0};
        run_raw(raw, "full_frame", 1'b0);

`ifdef SLIP_CRC16_EN
        pay = {8'h31, 8'h32, 8'h33};
        raw = {8'hC0, slip_enc(add_crc(pay)), 8'hC0};
        run_raw(raw, "crc_good", 1'b0);
        pay = add_crc(pay);
        pay[4] = pay[4] ^ 8'h01;
        raw = {8'hC0, slip_enc(pay), 8'hC0};
        run_raw(raw, "crc_bad", 1'b0);
`endif

        // Consumer stalls while a new frame arrives mid-drain; that frame is dropped, sync survives.
        rdy_mode   = 2;
        i_tx_ready = 1'b0;
        pay = {8'h0A, 8'h0B};
        raw = {8'hC0, slip_enc(add_crc(pay)), 8'hC0};
        foreach (raw[i]) send_byte(raw[i]);
        exp_cnt++;
        got_q = {};
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold/valid", int'(o_tx_valid), 1);
            chk("hold/data", int'(o_tx_data), 8'h0A);
            chk("hold/last", int'(o_tx_last), 0);
            if (k == 3) send_byte(8'h09);
            else if (k == 5) send_byte(8'hC0);
            else tick();
        end
        rdy_mode = 0;
        wait_idle("hold");
        repeat (2) tick();
        chk("hold/nbytes", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("hold/b0", int'(got_q[0]), 8'h0A);
            chk("hold/b1", int'(got_q[1]), 8'h0B);
        end
        chk("hold/frame_cnt", int'(o_frame_cnt), exp_cnt);
        pay = {8'h0E};
        raw = {slip_enc(add_crc(pay)), 8'hC0};
        run_raw(raw, "after_hold", 1'b0);

        rdy_mode = 1;
        for (int f = 0; f < 50; f++) begin
            int          mode;
            int          n;
            int          pos;
            logic [7:0]  bad_b;
            mode = $urandom_range(7, 0);
            n = (mode == 0) ? (MAX_LEN - 2 - CRC_EXTRA + $urandom_range(4, 0)) : $urandom_range(12, 1);
            pay = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(5, 0))
                    0: pay.push_back(8'hC0);
                    1: pay.push_back(8'hDB);
                    default: pay.push_back(8'($urandom));
                endcase
            end
            if (mode == 1) begin
                pay.push_back(8'($urandom));
                pay.push_back(8'($urandom));
            end else begin
                pay = add_crc(pay);
            end
            raw = slip_enc(pay);
            if (mode == 2) begin
                bad_b = 8'($urandom);
                if (bad_b == 8'hDC || bad_b == 8'hDD) bad_b = 8'h55;
                if ($urandom_range(1, 0) == 0) bad_b = 8'hC0;
                pos = $urandom_range(raw.size(), 0);
                raw.insert(pos, 8'hDB);
                raw.insert(pos + 1, bad_b);
            end
            if ($urandom_range(1, 0) == 0) raw.push_front(8'hC0);
            raw.push_back(8'hC0);
            run_raw(raw, $sformatf("rnd%0d", f), 1'b1);
        end

        // Reset in the middle of a stalled drain clears every output.
        rdy_mode   = 2;
        i_tx_ready = 1'b0;
        pay = {8'h21, 8'h22, 8'h23};
        raw = {8'hC0, slip_enc(add_crc(pay)), 8'hC0};
        foreach (raw[i]) send_byte(raw[i]);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid/valid", int'(o_tx_valid), 0);
        chk("rst_mid/last", int'(o_tx_last), 0);
        chk("rst_mid/data", int'(o_tx_data), 0);
        chk("rst_mid/busy", int'(o_busy), 0);
        chk("rst_mid/err", int'(o_err), 0);
        chk("rst_mid/frame_cnt", int'(o_frame_cnt), 0);
        chk("rst_mid/frame_len", int'(o_frame_len), 0);
        tick();
        reset    = 1'b0;
        exp_cnt  = 0;
        rdy_mode = 0;
        tick();
        pay = {8'h05};
        raw = {slip_enc(add_crc(pay)), 8'hC0};
        run_raw(raw, "after_reset", 1'b0);

        chk("err_consecutive", int'(err_consec), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
